phase_alu_exec: RTL and testbench

- Execute-stage core of the 8-phase multi-cycle CPU.
- Generates the one-hot 8-phase sequence that drives the fetch, decode, select, execute and writeback steps.
- Computes up to two ALU micro-operations per instruction, from the fetched opcode, the immediate and the selector-chosen register value.
- Routes the matching destination-register load code to the register file, stack memory and EIP.

---
 rtl/phase_alu_exec.sv | 120 ++++++++++++
 tb/tb_phase_alu_exec.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/phase_alu_exec.sv
// Execute-stage core of the 8-phase multi-cycle CPU: one-hot phase sequencer,
// two ALU micro-ops per instruction and the paired destination load code.
module phase_alu_exec #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PHASES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ope,
    input  logic [WIDTH-1:0]  imm,
    input  logic [WIDTH-1:0]  src,
    input  logic [3:0]        reg_load_1,
    input  logic [3:0]        reg_load_2,
    output logic [PHASES-1:0] phase,
    output logic [WIDTH-1:0]  alu_result,
    output logic [3:0]        selected_reg_load
);

    localparam int unsigned LOAD_W = 4;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_POP_EBP  = 8'h5D;
    localparam logic [7:0] OP_MOV_RM_R = 8'h89;
    localparam logic [7:0] OP_GRP1_I8  = 8'h83;
    localparam logic [7:0] MODRM_SUB   = 8'hEC;
    localparam logic [7:0] MODRM_ADD   = 8'hC4;

    logic [PHASES-1:0] phase_q;
    logic [WIDTH-1:0]  alu_result_q;
    logic [LOAD_W-1:0] sel_load_q;

    logic [7:0]        opcode;
    logic [7:0]        modrm;
    logic [WIDTH-1:0]  imm8_sext;
    logic [WIDTH-1:0]  op1_d;
    logic              op1_vld;
    logic [WIDTH-1:0]  op2_d;
    logic              op2_vld;
    logic              ope_unused;

    assign opcode     = ope[31:24];
    assign modrm      = ope[23:16];
    assign imm8_sext  = {{(WIDTH-8){ope[15]}}, ope[15:8]};
    assign ope_unused = ^ope[7:0];

    // Micro-op decode; a clear valid means the result register holds.
    always_comb begin
        op1_d   = '0;
        op1_vld = 1'b0;
        op2_d   = '0;
        op2_vld = 1'b0;
        unique case (opcode)
            OP_PUSH_EBP: begin
                op1_d   = src - WIDTH'(4);
                op1_vld = 1'b1;
                op2_d   = src;
                op2_vld = 1'b1;
            end
            OP_POP_EBP: begin
                op1_d   = src;
                op1_vld = 1'b1;
                op2_d   = src + WIDTH'(4);
                op2_vld = 1'b1;
            end
            OP_MOV_RM_R: begin
                op1_d   = src;
                op1_vld = 1'b1;
            end
            OP_GRP1_I8: begin
                if (modrm == MODRM_SUB) begin
                    op1_d   = src - imm8_sext;
                    op1_vld = 1'b1;
                end else if (modrm == MODRM_ADD) begin
                    op1_d   = src + imm8_sext;
                    op1_vld = 1'b1;
                end
            end
            default: begin
                if (opcode[7:3] == 5'b10111) begin
                    op1_d   = imm;
                    op1_vld = 1'b1;
                end
            end
        endcase
    end

    // Phase ring plus result/destination updates at the ends of phases 4, 6 and 8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            alu_result_q <= '0;
            sel_load_q   <= '0;
        end else begin
            if (phase_q == '0) begin
                phase_q <= PHASES'(1);
            end else begin
                phase_q <= {phase_q[PHASES-2:0], phase_q[PHASES-1]};
            end

            if (phase_q[3]) begin
                if (op1_vld) begin
                    alu_result_q <= op1_d;
                end
                sel_load_q <= reg_load_1;
            end else if (phase_q[5]) begin
                if (op2_vld) begin
                    alu_result_q <= op2_d;
                end
                sel_load_q <= reg_load_2;
            end else if (phase_q[7]) begin
                sel_load_q <= '0;
            end
        end
    end

    assign phase             = phase_q;
    assign alu_result        = alu_result_q;
    assign selected_reg_load = sel_load_q;

endmodule

// File: tb/tb_phase_alu_exec.sv
// Directed bench for phase_alu_exec: reset, phase ring and per-opcode micro-op results.
module tb_phase_alu_exec;

    logic        clk;
    logic        reset;
    logic [31:0] ope;
    logic [31:0] imm;
    logic [31:0] src;
    logic [3:0]  reg_load_1;
    logic [3:0]  reg_load_2;
    logic [7:0]  phase;
    logic [31:0] alu_result;
    logic [3:0]  selected_reg_load;

    int n_checks = 0;
    int n_pass   = 0;

    phase_alu_exec #(.WIDTH(32), .PHASES(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .ope               (ope),
        .imm               (imm),
        .src               (src),
        .reg_load_1        (reg_load_1),
        .reg_load_2        (reg_load_2),
        .phase             (phase),
        .alu_result        (alu_result),
        .selected_reg_load (selected_reg_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until phase k (1..8) is current, bounded to two full rings.
    task automatic to_phase(input int k);
        logic [7:0] want;
        int         n;
        want = 8'(1 << (k - 1));
        n    = 0;
        while (phase !== want && n < 16) begin
            step();
            n++;
        end
        if (phase !== want) begin
            check("to_phase_timeout", 32'(phase), 32'(want));
        end
    endtask

    // One instruction: op1 operands applied in phase 4, op2 operands in phase 5.
    task automatic do_instr(input string tag,
                            input logic [31:0] ope_v, input logic [31:0] imm_v,
                            input logic [31:0] src1, input logic [3:0] rl1,
                            input logic [31:0] src2, input logic [3:0] rl2,
                            input logic [31:0] exp1, input logic [31:0] exp2);
        to_phase(4);
        ope        = ope_v;
        imm        = imm_v;
        src        = src1;
        reg_load_1 = rl1;
        reg_load_2 = 4'hF;
        step();
        check({tag, "_p5_alu"}, alu_result, exp1);
        check({tag, "_p5_sel"}, 32'(selected_reg_load), 32'(rl1));
        src        = src2;
        reg_load_2 = rl2;
        reg_load_1 = 4'hE;
        step();
        check({tag, "_p6_alu"}, alu_result, exp1);
        check({tag, "_p6_sel"}, 32'(selected_reg_load), 32'(rl1));
        step();
        check({tag, "_p7_alu"}, alu_result, exp2);
        check({tag, "_p7_sel"}, 32'(selected_reg_load), 32'(rl2));
        src = 32'h0BAD_0BAD;
        imm = 32'h0BAD_0BAD;
        step();
        check({tag, "_p8_alu"}, alu_result, exp2);
        check({tag, "_p8_sel"}, 32'(selected_reg_load), 32'(rl2));
        step();
        check({tag, "_p1_phase"}, 32'(phase), 32'h01);
        check({tag, "_p1_alu"}, alu_result, exp2);
        check({tag, "_p1_sel"}, 32'(selected_reg_load), 32'h0);
        reg_load_1 = 4'h0;
        reg_load_2 = 4'h0;
    endtask

    initial begin
        logic [7:0] exp_phase;
        reset      = 1'b1;
        ope        = 32'h0;
        imm        = 32'h0;
        src        = 32'h0;
        reg_load_1 = 4'h0;
        reg_load_2 = 4'h0;

        repeat (2) step();
        check("rst_phase", 32'(phase), 32'h00);
        check("rst_alu", alu_result, 32'h0);
        check("rst_sel", 32'(selected_reg_load), 32'h0);

        @(negedge clk);
        reset = 1'b0;
        exp_phase = 8'h01;
        for (int i = 0; i < 9; i++) begin
            step();
            check("seq_phase", 32'(phase), 32'(exp_phase));
            check("seq_onehot", 32'($onehot(phase)), 32'h1);
            exp_phase = {exp_phase[6:0], exp_phase[7]};
        end

        do_instr("push", 32'h5500_0000, 32'h0, 32'h0000_0100, 4'd2,
                 32'h1234_5678, 4'd4, 32'h0000_00FC, 32'h1234_5678);
        do_instr("mov_rm", 32'h89E5_0000, 32'h0, 32'h0000_00FC, 4'd1,
                 32'hAAAA_5555, 4'd0, 32'h0000_00FC, 32'h0000_00FC);
        do_instr("sub_i8", 32'h83EC_0800, 32'h0, 32'h0000_0004, 4'd3,
                 32'h5555_AAAA, 4'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        do_instr("add_i8", 32'h83C4_F000, 32'h0, 32'h0000_0020, 4'd3,
                 32'h1111_1111, 4'd0, 32'h0000_0010, 32'h0000_0010);
        do_instr("mov_imm", 32'hB800_0000, 32'hDEAD_BEEF, 32'h0000_0001, 4'd1,
                 32'h2222_2222, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_instr("pop", 32'h5D00_0000, 32'h0, 32'hCAFE_F00D, 4'd5,
                 32'hFFFF_FFFE, 4'd6, 32'hCAFE_F00D, 32'h0000_0002);
        do_instr("unknown", 32'hFF00_0000, 32'h7777_7777, 32'h0000_1234, 4'd7,
                 32'h0000_5678, 4'd9, 32'h0000_0002, 32'h0000_0002);
        do_instr("grp1_other", 32'h83C0_0400, 32'h0, 32'h0000_0100, 4'd1,
                 32'h0000_0200, 4'd2, 32'h0000_0002, 32'h0000_0002);
        do_instr("mov_imm_bf", 32'hBF00_0000, 32'h0102_0304, 32'h0, 4'd8,
                 32'h0, 4'd0, 32'h0102_0304, 32'h0102_0304);
        do_instr("nop", 32'h9000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0,
                 32'hFFFF_FFFF, 4'd0, 32'h0102_0304, 32'h0102_0304);

        // Asynchronous reset in the middle of phase 5.
        do_instr("push2", 32'h5500_0000, 32'h0, 32'h0000_0010, 4'd2,
                 32'h0000_0099, 4'd4, 32'h0000_000C, 32'h0000_0099);
        to_phase(4);
        ope        = 32'hB800_0000;
        imm        = 32'h1357_9BDF;
        reg_load_1 = 4'd3;
        step();
        check("pre_rst_alu", alu_result, 32'h1357_9BDF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_phase", 32'(phase), 32'h00);
        check("async_rst_alu", alu_result, 32'h0);
        check("async_rst_sel", 32'(selected_reg_load), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_phase", 32'(phase), 32'h01);
        check("post_rst_alu", alu_result, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
